// File: rtl/axi_arbiter_rr.sv
// Purpose: round-robin / fixed-priority bus arbiter with a locked grant held for one burst and a forced release after MAX_BEATS beats.
// Latency: a new grant appears one cycle after the arbitration edge, and back-to-back grants leave no idle gap.
// Backpressure: only accepted beats (xfer_valid & xfer_ready) advance the burst, so a stalled slave holds the grant indefinitely.
module axi_arbiter_rr #(
    parameter int N_MASTERS = 6,
    parameter int MAX_BEATS = 16,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 mode,
    input  logic                 xfer_valid,
    input  logic                 xfer_ready,
    input  logic                 xfer_last,
    output logic [N_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 busy,
    output logic                 timeout
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     beat_cnt, beat_cnt_nxt;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [N_MASTERS-1:0] gnt_nxt;
    logic [IDX_W-1:0]     gnt_idx_nxt;
    logic                 busy_nxt;
    logic                 timeout_nxt;

    // Arbitration result and burst bookkeeping.
    logic                 arb_found;
    logic [IDX_W-1:0]     arb_idx;
    int                   arb_base;
    int                   arb_cand;
    logic                 beat;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 at_max;
    logic                 release_evt;
    logic                 forced_rel;
    logic                 arb_now;

    // Pick the winner: fixed priority searches from index 0, round-robin from rr_ptr.
    // rr_ptr already points past the current owner, so the owner is naturally last in line.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = 0;
        arb_base  = mode ? 0 : int'(rr_ptr);
        for (int k = 0; k < N_MASTERS; k++) begin
            arb_cand = (arb_base + k) % N_MASTERS;
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(arb_cand);
            end
        end
    end

    // Beat accounting: only accepted beats while owned count towards the burst limit.
    always_comb begin
        beat        = (state == OWNED) && xfer_valid && xfer_ready;
        cnt_inc     = beat_cnt + CNT_W'(1);
        at_max      = (cnt_inc == CNT_W'(MAX_BEATS));
        release_evt = beat && (xfer_last || at_max);
        forced_rel  = beat && !xfer_last && at_max;
        arb_now     = (state == IDLE) || release_evt;
    end

    // Next-state and next-output logic; mode is only consulted when arb_now is set.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        rr_ptr_nxt   = rr_ptr;
        gnt_nxt      = gnt;
        gnt_idx_nxt  = gnt_idx;
        busy_nxt     = busy;
        timeout_nxt  = forced_rel;

        if (beat) begin
            beat_cnt_nxt = cnt_inc;
        end

        if (arb_now) begin
            beat_cnt_nxt = '0;
            if (arb_found) begin
                state_nxt   = OWNED;
                gnt_nxt     = N_MASTERS'(1) << arb_idx;
                gnt_idx_nxt = arb_idx;
                busy_nxt    = 1'b1;
                if (!mode) begin
                    rr_ptr_nxt = (arb_idx == IDX_W'(N_MASTERS - 1)) ? '0 : arb_idx + IDX_W'(1);
                end
            end else begin
                state_nxt   = IDLE;
                gnt_nxt     = '0;
                gnt_idx_nxt = '0;
                busy_nxt    = 1'b0;
            end
        end
    end

    // State and output registers; reset overrides every other event at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            rr_ptr   <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= gnt_idx_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_axi_arbiter_rr.sv
module tb_axi_arbiter_rr;

    logic       clk;
    logic       rst_n;
    logic [5:0] req;
    logic       mode;
    logic       xfer_valid;
    logic       xfer_ready;
    logic       xfer_last;
    logic [5:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    axi_arbiter_rr #(
        .N_MASTERS(6),
        .MAX_BEATS(4),
        .IDX_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .mode(mode),
        .xfer_valid(xfer_valid),
        .xfer_ready(xfer_ready),
        .xfer_last(xfer_last),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .busy(busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs held for one cycle, and the outputs expected right after that edge.
    typedef struct {
        logic       rst_n;
        logic [5:0] req;
        logic       mode;
        logic [2:0] vrl;   // {xfer_valid, xfer_ready, xfer_last}
        logic [5:0] e_gnt;
        logic [2:0] e_idx;
        logic       e_busy;
        logic       e_to;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [5:0] rq, input logic m, input logic [2:0] vrl,
                       input logic [5:0] eg, input logic [2:0] ei, input logic eb, input logic et);
        vec_t v;
        v.rst_n = r; v.req = rq; v.mode = m; v.vrl = vrl;
        v.e_gnt = eg; v.e_idx = ei; v.e_busy = eb; v.e_to = et;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d busy=%b to=%b, want gnt=%b idx=%0d busy=%b to=%b",
                     name, act[10:5], act[4:2], act[1], act[0], exp[10:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] rq, input logic m, input logic [2:0] vrl);
        rst_n = r; req = rq; mode = m;
        {xfer_valid, xfer_ready, xfer_last} = vrl;
    endtask

    initial begin
        int n;
        bit seen;
        drive(1'b0, 6'b0, 1'b0, 3'b000);

        // Reset ignores req.
        add(0, 6'b111111, 0, 3'b111, 6'b000000, 0, 0, 0);
        // Single requester, one-cycle grant latency, release into idle.
        add(1, 6'b000001, 0, 3'b000, 6'b000001, 0, 1, 0);
        add(1, 6'b000000, 0, 3'b111, 6'b000000, 0, 0, 0);
        add(0, 6'b111111, 0, 3'b000, 6'b000000, 0, 0, 0);
        // Fixed-priority grant must leave rr_ptr at 0.
        add(1, 6'b111111, 1, 3'b000, 6'b000001, 0, 1, 0);
        add(1, 6'b000000, 1, 3'b111, 6'b000000, 0, 0, 0);
        // Round-robin sweep with all requesting, no idle gaps.
        add(1, 6'b111111, 0, 3'b000, 6'b000001, 0, 1, 0);
        add(1, 6'b111111, 0, 3'b111, 6'b000010, 1, 1, 0);
        add(1, 6'b111111, 0, 3'b111, 6'b000100, 2, 1, 0);
        add(1, 6'b111111, 0, 3'b111, 6'b001000, 3, 1, 0);
        add(1, 6'b111111, 0, 3'b111, 6'b010000, 4, 1, 0);
        add(1, 6'b111111, 0, 3'b111, 6'b100000, 5, 1, 0);
        add(1, 6'b111111, 0, 3'b111, 6'b000001, 0, 1, 0);
        add(1, 6'b000000, 0, 3'b111, 6'b000000, 0, 0, 0);
        // Beat while idle is ignored.
        add(1, 6'b000000, 0, 3'b111, 6'b000000, 0, 0, 0);
        // Fixed priority: idx 2 wins every time.
        add(1, 6'b101100, 1, 3'b000, 6'b000100, 2, 1, 0);
        add(1, 6'b101100, 1, 3'b111, 6'b000100, 2, 1, 0);
        add(1, 6'b101100, 1, 3'b111, 6'b000100, 2, 1, 0);
        add(1, 6'b101100, 1, 3'b111, 6'b000100, 2, 1, 0);
        add(1, 6'b000000, 1, 3'b111, 6'b000000, 0, 0, 0);
        // Locked grant: owner 3 drops req, 1 raises; mode flips mid-burst.
        add(1, 6'b001000, 0, 3'b000, 6'b001000, 3, 1, 0);
        add(1, 6'b000010, 0, 3'b110, 6'b001000, 3, 1, 0);
        add(1, 6'b000010, 1, 3'b000, 6'b001000, 3, 1, 0);
        add(1, 6'b000010, 0, 3'b111, 6'b000010, 1, 1, 0);
        // Forced release after 4 beats, timeout pulses once.
        add(1, 6'b000101, 0, 3'b110, 6'b000010, 1, 1, 0);
        add(1, 6'b000101, 0, 3'b110, 6'b000010, 1, 1, 0);
        add(1, 6'b000101, 0, 3'b110, 6'b000010, 1, 1, 0);
        add(1, 6'b000101, 0, 3'b110, 6'b000100, 2, 1, 1);
        add(1, 6'b000101, 0, 3'b000, 6'b000100, 2, 1, 0);
        // 4th beat carries last: normal release, no timeout.
        add(1, 6'b000001, 0, 3'b110, 6'b000100, 2, 1, 0);
        add(1, 6'b000001, 0, 3'b110, 6'b000100, 2, 1, 0);
        add(1, 6'b000001, 0, 3'b110, 6'b000100, 2, 1, 0);
        add(1, 6'b000001, 0, 3'b111, 6'b000001, 0, 1, 0);
        // Reset mid-burst after 2 beats, then resume from rr_ptr = 0.
        add(1, 6'b000001, 0, 3'b110, 6'b000001, 0, 1, 0);
        add(1, 6'b000001, 0, 3'b110, 6'b000001, 0, 1, 0);
        add(0, 6'b111111, 0, 3'b111, 6'b000000, 0, 0, 0);
        add(1, 6'b000100, 0, 3'b000, 6'b000100, 2, 1, 0);
        // Releasing owner is lowest priority in round-robin.
        add(1, 6'b000100, 0, 3'b111, 6'b000100, 2, 1, 0);
        add(1, 6'b000101, 0, 3'b111, 6'b000001, 0, 1, 0);
        add(1, 6'b100001, 0, 3'b111, 6'b100000, 5, 1, 0);
        add(1, 6'b000000, 0, 3'b111, 6'b000000, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].req, tbl[i].mode, tbl[i].vrl);
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), {gnt, gnt_idx, busy, timeout},
                  {tbl[i].e_gnt, tbl[i].e_idx, tbl[i].e_busy, tbl[i].e_to});
        end

        // Streaming owner: timeout must arrive after exactly MAX_BEATS beats and last one cycle.
        drive(1'b0, 6'b000000, 1'b0, 3'b000);
        @(posedge clk); #1;
        drive(1'b1, 6'b000010, 1'b0, 3'b000);
        @(posedge clk); #1;
        check("stream_grant", {gnt, gnt_idx, busy, timeout}, {6'b000010, 3'd1, 1'b1, 1'b0});
        drive(1'b1, 6'b000010, 1'b0, 3'b110);
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = timeout;
        end
        checks++;
        if (!seen || n != 4) begin
            errors++;
            $display("FAIL stream_timeout_beats: got seen=%0d after %0d cycles, want 1 after 4", seen, n);
        end
        check("stream_regrant", {gnt, gnt_idx, busy, timeout}, {6'b000010, 3'd1, 1'b1, 1'b1});
        @(posedge clk); #1;
        check("stream_pulse_end", {gnt, gnt_idx, busy, timeout}, {6'b000010, 3'd1, 1'b1, 1'b0});
        drive(1'b1, 6'b000000, 1'b0, 3'b000);
        @(posedge clk); #1;
        check("stream_stall", {gnt, gnt_idx, busy, timeout}, {6'b000010, 3'd1, 1'b1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
